// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared-memory arbiter between instruction fetch and data access (optional ARB_ROUND_ROBIN_EN)
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   if_rdata_q;
    logic [15:0]   dm_rdata_q;
    logic          if_done_q;
    logic          dm_done_q;
    logic          mem_en_q;
    logic          mem_wr_q;
    logic [15:0]   mem_addr_q;
    logic [15:0]   mem_wdata_q;
    logic          err_q;
    logic          grant_dm;
`ifdef ARB_ROUND_ROBIN_EN
    logic          last_dm_q;
`endif

    // Pick the data port when it requests, unless round-robin says fetch is owed a turn
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_dm = dm_req && (!if_req || !last_dm_q);
`else
        grant_dm = dm_req;
`endif
    end

    // Arbitration FSM with registered memory command, read data, done pulses and timeout error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dm_q   <= 1'b0;
`endif
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            mem_en_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req || dm_req) begin
                        cnt_q    <= '0;
                        mem_en_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_dm_q <= grant_dm;
`endif
                        if (grant_dm) begin
                            state_q     <= BUSY_DM;
                            mem_wr_q    <= dm_wr;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                        end else begin
                            state_q     <= BUSY_IF;
                            mem_wr_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (mem_done) begin
                        state_q     <= IDLE;
                        mem_wr_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        if (state_q == BUSY_IF) begin
                            if_rdata_q <= mem_rdata;
                            if_done_q  <= 1'b1;
                        end else begin
                            // Stores leave the last load value visible
                            if (!mem_wr_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                            dm_done_q <= 1'b1;
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        // Abandon the transaction silently; only err reports it
                        state_q     <= IDLE;
                        err_q       <= 1'b1;
                        mem_wr_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign if_stall  = if_req && !if_done_q;
    assign dm_stall  = dm_req && !dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .dm_stall  (dm_stall),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic exp_dm;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = 16'h0;
        dm_req    = 1'b0;
        dm_wr     = 1'b0;
        dm_addr   = 16'h0;
        dm_wdata  = 16'h0;
        mem_rdata = 16'h0;
        mem_done  = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_mem_en",   mem_en,    0);
        chk("rst_mem_addr", mem_addr,  0);
        chk("rst_if_rdata", if_rdata,  0);
        chk("rst_dm_rdata", dm_rdata,  0);
        chk("rst_done",     {if_done, dm_done}, 0);
        chk("rst_err",      err,       0);
        rst = 1'b0;

        // fetch read, done one cycle after issue, request dropped mid-way
        if_req  = 1'b1;
        if_addr = 16'h0010;
        tick();
        chk("if_mem_en1",  mem_en,   1);
        chk("if_mem_addr", mem_addr, 16'h0010);
        chk("if_mem_wr",   mem_wr,   0);
        chk("if_stall1",   if_stall, 1);
        if_req = 1'b0;
        tick();
        chk("if_mem_en2",   mem_en,   0);
        chk("if_addr_hold", mem_addr, 16'h0010);
        chk("if_no_done",   if_done,  0);
        mem_done  = 1'b1;
        mem_rdata = 16'hA5A5;
        tick();
        mem_done = 1'b0;
        chk("if_done",      if_done,  1);
        chk("if_rdata",     if_rdata, 16'hA5A5);
        chk("if_idle_addr", mem_addr, 0);
        tick();
        chk("if_done_pulse", if_done, 0);

        // data read with completion in the issue cycle
        dm_req  = 1'b1;
        dm_wr   = 1'b0;
        dm_addr = 16'h0300;
        tick();
        chk("dr_mem_en",   mem_en,   1);
        chk("dr_mem_addr", mem_addr, 16'h0300);
        dm_req    = 1'b0;
        mem_done  = 1'b1;
        mem_rdata = 16'h5A5A;
        tick();
        mem_done = 1'b0;
        chk("dr_done",  dm_done,  1);
        chk("dr_rdata", dm_rdata, 16'h5A5A);
        tick();

        // data write leaves dm_rdata untouched
        dm_req   = 1'b1;
        dm_wr    = 1'b1;
        dm_addr  = 16'h0200;
        dm_wdata = 16'h1234;
        tick();
        chk("dw_mem_en",    mem_en,    1);
        chk("dw_mem_wr",    mem_wr,    1);
        chk("dw_mem_addr",  mem_addr,  16'h0200);
        chk("dw_mem_wdata", mem_wdata, 16'h1234);
        chk("dw_stall",     dm_stall,  1);
        dm_req    = 1'b0;
        mem_done  = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_done = 1'b0;
        chk("dw_done",   dm_done,  1);
        chk("dw_rdata",  dm_rdata, 16'h5A5A);
        chk("dw_wr_clr", mem_wr,   0);
        dm_wr = 1'b0;

        // simultaneous requests held for four transactions, from a fresh reset
        do_reset();
        if_req  = 1'b1;
        if_addr = 16'h0100;
        dm_req  = 1'b1;
        dm_addr = 16'h0400;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_dm = (k % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            tick();
            chk("arb_mem_en", mem_en, 1);
            chk("arb_addr", mem_addr, exp_dm ? 16'h0400 : 16'h0100);
            mem_done  = 1'b1;
            mem_rdata = 16'h1000 + 16'(k);
            tick();
            mem_done = 1'b0;
            chk("arb_dm_done",  dm_done,  exp_dm);
            chk("arb_if_done",  if_done,  !exp_dm);
            chk("arb_if_stall", if_stall, exp_dm);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        tick();

        // timeout after 15 busy cycles without completion
        if_req  = 1'b1;
        if_addr = 16'h0020;
        tick();
        if_req = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        chk("to_err_before",  err,      0);
        chk("to_addr_before", mem_addr, 16'h0020);
        tick();
        chk("to_err",     err,      1);
        chk("to_no_done", if_done,  0);
        chk("to_idle",    mem_addr, 0);
        tick();
        chk("to_no_done2", if_done, 0);
        chk("to_sticky",   err,     1);

        // arbitration keeps working with err set
        dm_req  = 1'b1;
        dm_addr = 16'h0500;
        tick();
        chk("post_err_en", mem_en, 1);
        dm_req    = 1'b0;
        mem_done  = 1'b1;
        mem_rdata = 16'hC3C3;
        tick();
        mem_done = 1'b0;
        chk("post_err_done",  dm_done,  1);
        chk("post_err_rdata", dm_rdata, 16'hC3C3);
        chk("post_err_err",   err,      1);
        do_reset();
        chk("err_cleared", err, 0);

        // asynchronous reset during the second busy cycle of a data write
        dm_req   = 1'b1;
        dm_wr    = 1'b1;
        dm_addr  = 16'h0600;
        dm_wdata = 16'h7777;
        tick();
        dm_req = 1'b0;
        tick();
        chk("mid_addr", mem_addr, 16'h0600);
        rst = 1'b1;
        #1;
        chk("mid_rst_en",    mem_en,    0);
        chk("mid_rst_wr",    mem_wr,    0);
        chk("mid_rst_addr",  mem_addr,  0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_rdata", dm_rdata,  0);
        chk("mid_rst_done",  dm_done,   0);
        tick();
        rst = 1'b0;
        dm_wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_no_done", dm_done, 0);
            chk("mid_no_en",   mem_en,  0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
